masking_prng: RTL and testbench

Free-running pseudo-random bit source that supplies fresh masking randomness every cycle to the shared-zero generator and the masked S-box stages. The source is a 128-bit Fibonacci LFSR, seeded through a 32-bit valid/ready word interface and stepped `OUT_WIDTH` times per clock (unrolled). The block suppresses output during seeding and warm-up, and supports reseeding while running.

---
 rtl/masking_prng.sv | 121 ++++++++++++
 tb/tb_masking_prng.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/masking_prng.sv
// masking_prng: free-running 128-bit Fibonacci LFSR producing OUT_WIDTH fresh
// masking bits per clock. Seeded through a 32-bit valid/ready word stream;
// output is suppressed while loading and during a programmable warm-up.
module masking_prng #(
    parameter int unsigned OUT_WIDTH     = 8,
    parameter int unsigned WARMUP_CYCLES = 16
) (
    input  logic                 in_clock,
    input  logic                 in_reset,
    input  logic [31:0]          in_seed,
    input  logic                 in_seed_valid,
    output logic                 out_seed_ready,
    output logic [OUT_WIDTH-1:0] out_random,
    output logic                 out_random_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOADING,
        ST_WARMUP,
        ST_RUN
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   s_q, s_d;
    logic [1:0]     word_cnt_q, word_cnt_d;
    logic [7:0]     warm_cnt_q, warm_cnt_d;
    logic           accept;
    logic [127:0]   s_shifted;
    logic [127:0]   s_stepped;

    // OUT_WIDTH unrolled LFSR steps, taps 127/125/100/98
    function automatic logic [127:0] lfsr_advance(input logic [127:0] s);
        logic [127:0] r;
        r = s;
        for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
            r = {r[126:0], r[127] ^ r[125] ^ r[100] ^ r[98]};
        end
        return r;
    endfunction

    // State register and datapath flops, synchronous reset
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            word_cnt_q <= '0;
            warm_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            word_cnt_q <= word_cnt_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    // Next-state and datapath update; a seed accept always beats stepping
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        word_cnt_d = word_cnt_q;
        warm_cnt_d = warm_cnt_q;
        accept     = in_seed_valid && (state_q != ST_WARMUP);
        s_shifted  = {s_q[95:0], in_seed};
        s_stepped  = lfsr_advance(s_q);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    s_d        = s_shifted;
                    word_cnt_d = 2'd1;
                    state_d    = ST_LOADING;
                end
            end
            ST_LOADING: begin
                if (accept) begin
                    s_d        = s_shifted;
                    word_cnt_d = word_cnt_q + 2'd1;
                    if (word_cnt_q == 2'd3) begin
                        // an all-zero state would lock the LFSR forever
                        if (s_shifted == '0) begin
                            s_d = 128'h1;
                        end
                        if (WARMUP_CYCLES == 0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d    = ST_WARMUP;
                            warm_cnt_d = 8'(WARMUP_CYCLES);
                        end
                    end
                end
            end
            ST_WARMUP: begin
                s_d        = s_stepped;
                warm_cnt_d = warm_cnt_q - 8'd1;
                if (warm_cnt_q <= 8'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    s_d        = s_shifted;
                    word_cnt_d = 2'd1;
                    state_d    = ST_LOADING;
                end else begin
                    s_d = s_stepped;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        out_seed_ready   = (state_q != ST_WARMUP);
        out_random_valid = (state_q == ST_RUN);
        out_random       = out_random_valid ? s_q[OUT_WIDTH-1:0] : '0;
    end

endmodule

// File: tb/tb_masking_prng.sv
// tb_masking_prng: directed, table-driven checks of masking_prng with two
// instances (no warm-up and 16-cycle warm-up) sharing one seed stream.
module tb_masking_prng;

    logic        clk = 1'b0;
    logic        in_reset;
    logic [31:0] in_seed;
    logic        in_seed_valid;

    logic        rdy0, v0, rdy1, v1;
    logic [7:0]  r0, r1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    masking_prng #(.OUT_WIDTH(8), .WARMUP_CYCLES(0)) dut0 (
        .in_clock(clk), .in_reset(in_reset), .in_seed(in_seed),
        .in_seed_valid(in_seed_valid), .out_seed_ready(rdy0),
        .out_random(r0), .out_random_valid(v0));

    masking_prng #(.OUT_WIDTH(8), .WARMUP_CYCLES(16)) dut1 (
        .in_clock(clk), .in_reset(in_reset), .in_seed(in_seed),
        .in_seed_valid(in_seed_valid), .out_seed_ready(rdy1),
        .out_random(r1), .out_random_valid(v1));

    typedef struct {
        logic [127:0] seed;
        logic [7:0]   exp0;
        logic [7:0]   exp1;
    } vec_t;

    vec_t vecs[6];

    // Reference LFSR: n single steps
    function automatic logic [127:0] ref_steps(input logic [127:0] s, input int n);
        logic [127:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = {r[126:0], r[127] ^ r[125] ^ r[100] ^ r[98]};
        return r;
    endfunction

    function automatic logic [127:0] guarded(input logic [127:0] s);
        return (s == '0) ? 128'h1 : s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic with_valid);
        in_reset      = 1'b1;
        in_seed_valid = with_valid;
        in_seed       = 32'hFFFF_FFFF;
        tick();
        tick();
        in_reset      = 1'b0;
        in_seed_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        in_seed       = w;
        in_seed_valid = 1'b1;
        tick();
        in_seed_valid = 1'b0;
    endtask

    task automatic send_seed(input logic [127:0] seed);
        for (int i = 0; i < 4; i++) send_word(seed[127 - 32*i -: 32]);
    endtask

    // Called just after the accepting edge of word 4 on dut0
    task automatic check_stream(input string name, input logic [127:0] seed, input int n);
        logic [127:0] exp;
        int bad;
        exp = guarded(seed);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (v0 !== 1'b1 || r0 !== exp[7:0]) bad++;
            exp = ref_steps(exp, 8);
            tick();
        end
        check(name, 128'(bad), 128'd0);
    endtask

    initial begin
        logic [127:0] exp;
        logic [127:0] rs;
        int bad, run, max_run;

        vecs[0] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 8'h00, 8'h80};
        vecs[1] = '{128'h0,                                       8'h01, 8'h00};
        vecs[2] = '{128'hC000_0000_0000_0000_0000_0000_0000_1234, 8'h34, 8'hC0};
        vecs[3] = '{128'h0000_0010_0000_0000_0000_0000_0000_00FF, 8'hFF, 8'h80};
        vecs[4] = '{128'h0000_0004_0000_0000_0000_0000_0000_0055, 8'h55, 8'hA0};
        vecs[5] = '{128'h0000_0014_0000_0000_0000_0000_0000_0000, 8'h00, 8'h20};

        in_reset = 1'b0; in_seed = '0; in_seed_valid = 1'b0;

        // Reset with seed valid held high through the last reset edge
        do_reset(1'b1);
        check("reset_ready", 128'(rdy0), 128'd1);
        check("reset_valid", 128'(v0), 128'd0);
        check("reset_random", 128'(r0), 128'd0);
        check("reset_ready_wu", 128'(rdy1), 128'd1);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        check("reset_no_accept_valid", 128'(v0), 128'd0);
        check("reset_no_accept_ready", 128'(rdy0), 128'd1);
        send_word(32'h4444_4444);
        check_stream("reset_then_seed", 128'h1111_1111_2222_2222_3333_3333_4444_4444, 4);

        // Table of hand-computed first two outputs, no warm-up
        for (int i = 0; i < 6; i++) begin
            do_reset(1'b0);
            send_seed(vecs[i].seed);
            check($sformatf("vec%0d_valid", i), 128'(v0), 128'd1);
            check($sformatf("vec%0d_first", i), 128'(r0), 128'(vecs[i].exp0));
            tick();
            check($sformatf("vec%0d_second", i), 128'(r0), 128'(vecs[i].exp1));
        end

        // Zero seed: guarded state never leaves output at zero for long
        do_reset(1'b0);
        send_seed(128'h0);
        exp = 128'h1; bad = 0; run = 0; max_run = 0;
        for (int i = 0; i < 300; i++) begin
            if (r0 !== exp[7:0]) bad++;
            if (r0 == 8'h00) run++; else run = 0;
            if (run > max_run) max_run = run;
            exp = ref_steps(exp, 8);
            tick();
        end
        check("zero_guard_stream", 128'(bad), 128'd0);
        check("zero_guard_max_zero_run_le16", 128'(max_run <= 16), 128'd1);

        // Warm-up of 16 cycles on dut1
        do_reset(1'b0);
        rs = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
        send_seed(rs);
        check("wu_ready_low", 128'(rdy1), 128'd0);
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (v1 !== 1'b0 || rdy1 !== 1'b0 || r1 !== 8'h00) bad++;
        end
        check("wu_hold_low", 128'(bad), 128'd0);
        tick();
        check("wu_valid_at_16", 128'(v1), 128'd1);
        check("wu_ready_after", 128'(rdy1), 128'd1);
        exp = ref_steps(rs, 16*8);
        check("wu_first_value", 128'(r1), 128'(exp[7:0]));
        tick();
        exp = ref_steps(exp, 8);
        check("wu_second_value", 128'(r1), 128'(exp[7:0]));

        // Gapped seeding yields the gap-free stream
        do_reset(1'b0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(rs[127 - 32*i -: 32]);
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    if (v0 !== 1'b0 || rdy0 !== 1'b1) bad++;
                    tick();
                end
            end
        end
        check("gap_stall_outputs", 128'(bad), 128'd0);
        check_stream("gap_stream", rs, 20);

        // Reset after two words discards them
        do_reset(1'b0);
        send_word(32'hDEAD_BEEF);
        send_word(32'hCAFE_F00D);
        do_reset(1'b0);
        send_seed(128'hA5A5_0001_5A5A_0002_1234_0003_8765_0004);
        check_stream("midload_reset_stream", 128'hA5A5_0001_5A5A_0002_1234_0003_8765_0004, 20);

        // Reseed while running
        in_seed       = 32'h0BAD_F00D;
        in_seed_valid = 1'b1;
        check("reseed_valid_in_accept_cycle", 128'(v0), 128'd1);
        tick();
        in_seed_valid = 1'b0;
        check("reseed_valid_drops", 128'(v0), 128'd0);
        check("reseed_random_zero", 128'(r0), 128'd0);
        check("reseed_ready", 128'(rdy0), 128'd1);
        send_word(32'h1357_9BDF);
        send_word(32'h2468_ACE0);
        send_word(32'hFEDC_BA98);
        check_stream("reseed_stream", 128'h0BAD_F00D_1357_9BDF_2468_ACE0_FEDC_BA98, 20);

        // Long random-seed run against the reference LFSR
        do_reset(1'b0);
        rs = {$urandom, $urandom, $urandom, $urandom};
        send_seed(rs);
        check_stream("long_random_stream", rs, 10000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
